id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Pipeline hazard controller in the ID stage.
- Drives the write enables and kill controls of the PC, IF/ID and ID/EX registers, so it sits directly upstream of the ID/EX register's we and kill_control inputs.
- Detects load-use hazards and inserts bubbles for them.
- Flushes wrong-path instructions after a taken branch or jump resolved in EX.
- Freezes the whole front end while data memory is busy.
- Multi-cycle stall and flush sequences are handled by a small FSM with a down-counter.

Parameters:
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 or 2; use 2 when no MEM-to-EX forwarding exists).
- FLUSH_CYCLES, 1, cycles that ID/EX is killed after a taken branch (1..3).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_rs  in  [0:4]  rs field of the instruction in ID
- id_rt  in  [0:4]  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- idex_MemRead  in  1  instruction in EX is a load
- idex_DestReg  in  [0:4]  destination register of the instruction in EX
- exmem_MemRead  in  1  instruction in MEM is a load
- exmem_DestReg  in  [0:4]  destination register of the instruction in MEM
- branch_taken  in  1  EX resolved a taken branch/jump this cycle (PC mux selects the target)
- dmem_wait  in  1  data memory not ready; freeze the pipeline
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  load a NOP into IF/ID
- idex_we  out  1  ID/EX write enable
- idex_kill  out  1  zero ID/EX control bits (drives kill_control)
- busy  out  1  FSM not in RUN

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset:
  - rst high on a rising edge: state=RUN, cnt=0.
  - While rst is high, outputs are forced to pc_we=1, ifid_we=1, ifid_flush=1, idex_we=1, idex_kill=1, busy=0, so the pipeline fills with bubbles.
  - Reset mid-stall or mid-flush aborts the sequence immediately.
- Output timing: outputs are combinational from the current state, cnt and inputs, valid in the same cycle; there are no output registers.
- Hazard definition: hazEX = idex_MemRead & idex_DestReg!=0 & ((id_uses_rs & id_rs==idex_DestReg) | (id_uses_rt & id_rt==idex_DestReg)).
  - hazMEM is the same expression using exmem_*.
  - hazMEM is evaluated only when LU_STALL_CYCLES=2.
  - Register 0 never causes a hazard.
- Priority, highest first: rst, dmem_wait, branch_taken, load-use.
- Freeze (any state, dmem_wait=1):
  - pc_we=0, ifid_we=0, idex_we=0, ifid_flush=0, idex_kill=0.
  - State and cnt hold.
  - branch_taken is ignored during freeze; EX holds it, so it is reasserted after the wait.
- RUN:
  - branch_taken=1: pc_we=1, ifid_we=1, ifid_flush=1, idex_we=1, idex_kill=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - hazEX, or hazMEM when enabled: pc_we=0, ifid_we=0, ifid_flush=0, idex_we=1, idex_kill=1.
    - hazEX with LU_STALL_CYCLES=2: go to LU_STALL with cnt=1.
    - Otherwise stay in RUN; the hazard re-evaluates next cycle.
  - Otherwise all enables are 1 and all kills are 0.
- LU_STALL:
  - Outputs are the load-use pattern.
  - cnt decrements each non-frozen cycle; return to RUN when cnt reaches 0.
  - branch_taken=1 aborts the stall and behaves exactly as branch_taken in RUN.
- FLUSH:
  - pc_we=1, ifid_we=1, ifid_flush=1, idex_we=1, idex_kill=1.
  - cnt decrements; go to RUN when cnt reaches 0.
  - A new branch_taken in FLUSH reloads cnt=FLUSH_CYCLES-1.
- busy=1 in LU_STALL and FLUSH.
- Simultaneous events: branch_taken and a load-use hazard in the same cycle resolve as a flush only; the hazard belongs to the killed path.

Optional Feature:
- Macro HAZ_STATS_EN.
- Defined:
  - Adds outputs stall_cnt [0:31] and flush_cnt [0:31], both cleared by rst.
  - stall_cnt increments on every load-use bubble cycle.
  - flush_cnt increments on every cycle with idex_kill=1 caused by branch/flush.
  - Neither counter increments during freeze; both wrap modulo 2^32.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst 2 cycles -> ifid_flush=1, idex_kill=1, all we=1, busy=0; first cycle after rst -> kills=0.
- Load-use: idex_MemRead=1, idex_DestReg=5, id_rs=5, id_uses_rs=1 -> pc_we=0, ifid_we=0, idex_kill=1 for 1 cycle (2 cycles with LU_STALL_CYCLES=2, busy=1 on the second); repeat with DestReg=0 -> no stall.
- Branch: branch_taken=1 with FLUSH_CYCLES=2 -> ifid_flush=1 and idex_kill=1 for 2 cycles, pc_we=1 throughout, then RUN.
- Priority: branch_taken=1 with hazEX=1 -> flush pattern (pc_we=1), no stall; branch_taken during LU_STALL -> immediate flush.
- Freeze: dmem_wait=1 for 3 cycles mid-FLUSH (cnt=1) -> all we=0, kills=0; after release, one more flush cycle, then RUN.
- HAZ_STATS_EN: two load-use hazards and one branch with FLUSH_CYCLES=1 -> stall_cnt=2, flush_cnt=1; rst clears both to 0.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl
// Purpose : ID-stage hazard controller. Generates write enables and kill
//           controls for the PC, IF/ID and ID/EX registers. It handles
//           load-use bubbles, the wrong-path flush after a taken branch/jump,
//           and the front-end freeze while data memory is busy.
// Optional: define HAZ_STATS_EN to add the stall_cnt/flush_cnt statistics
//           outputs.
// Ports   :
//   clk, rst                      clock, synchronous active-high reset
//   id_rs/id_rt, id_uses_rs/rt    source registers of the ID instruction
//   idex_MemRead/idex_DestReg     load in EX and its destination register
//   exmem_MemRead/exmem_DestReg   load in MEM and its destination register
//   branch_taken                  taken branch/jump resolved in EX
//   dmem_wait                     data memory busy; freeze the pipeline
//   pc_we, ifid_we, idex_we       register write enables
//   ifid_flush, idex_kill         bubble injection into IF/ID and ID/EX
//   busy                          sequence in progress (FSM not in RUN)
//   stall_cnt, flush_cnt          (HAZ_STATS_EN) bubble/flush cycle counters
// Outputs are combinational from the current state, cnt and inputs.
// ---------------------------------------------------------------------------
module id_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        idex_MemRead,
  input  logic [4:0]  idex_DestReg,
  input  logic        exmem_MemRead,
  input  logic [4:0]  exmem_DestReg,
  input  logic        branch_taken,
  input  logic        dmem_wait,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_we,
  output logic        idex_kill,
  output logic        busy
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam bit LU_TWO      = (LU_STALL_CYCLES == 2);
  localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             haz_ex_c, haz_mem_c, lu_haz_c;

  // Load-use detection against EX and (two-bubble config only) MEM; r0 never hazards.
  always_comb begin
    haz_ex_c  = idex_MemRead && (idex_DestReg != 5'd0) &&
                ((id_uses_rs && (id_rs == idex_DestReg)) ||
                 (id_uses_rt && (id_rt == idex_DestReg)));
    haz_mem_c = exmem_MemRead && (exmem_DestReg != 5'd0) &&
                ((id_uses_rs && (id_rs == exmem_DestReg)) ||
                 (id_uses_rt && (id_rt == exmem_DestReg)));
    lu_haz_c  = haz_ex_c || (LU_TWO && haz_mem_c);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a freeze holds state and cnt.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!dmem_wait) begin
      if (branch_taken) begin
        // Taken branch wins in every state; a single-cycle flush needs no FSM help.
        if (MULTI_FLUSH) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_RELOAD;
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end else begin
        case (state_q)
          ST_RUN: begin
            // Only an EX-stage load needs a second bubble; a MEM hit re-evaluates.
            if (LU_TWO && haz_ex_c) begin
              state_d = ST_LU_STALL;
              cnt_d   = CNT_W'(1);
            end
          end
          ST_LU_STALL, ST_FLUSH: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end
          end
          default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // Output decode: rst > dmem_wait > branch/flush > load-use.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_we    = 1'b1;
    idex_kill  = 1'b0;
    busy       = (state_q != ST_RUN);
    if (rst) begin
      ifid_flush = 1'b1;
      idex_kill  = 1'b1;
      busy       = 1'b0;
    end else if (dmem_wait) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
    end else if (branch_taken || (state_q == ST_FLUSH)) begin
      ifid_flush = 1'b1;
      idex_kill  = 1'b1;
    end else if ((state_q == ST_LU_STALL) || lu_haz_c) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idex_kill = 1'b1;
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        stall_inc_c, flush_inc_c;

  // Classify the current cycle exactly as the output decode does.
  always_comb begin
    flush_inc_c = !rst && !dmem_wait && (branch_taken || (state_q == ST_FLUSH));
    stall_inc_c = !rst && !dmem_wait && !branch_taken && (state_q != ST_FLUSH) &&
                  ((state_q == ST_LU_STALL) || lu_haz_c);
    stall_cnt_d = stall_cnt_q + 32'(stall_inc_c);
    flush_cnt_d = flush_cnt_q + 32'(flush_inc_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_hazard_ctrl
// Three controller configurations share one stimulus stream:
//   cfg0: LU_STALL_CYCLES=1, FLUSH_CYCLES=1
//   cfg1: LU_STALL_CYCLES=2, FLUSH_CYCLES=2
//   cfg2: LU_STALL_CYCLES=1, FLUSH_CYCLES=3
// A directed vector table (expected values for cfg1), a hand sequence for the
// statistics counters, and a random phase are all checked against a
// behavioural model that tracks remaining flush/stall cycles as plain ints.
// ---------------------------------------------------------------------------
module tb_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, idex_DestReg, exmem_DestReg;
  logic       id_uses_rs, id_uses_rt, idex_MemRead, exmem_MemRead;
  logic       branch_taken, dmem_wait;
  logic [2:0] pc_we, ifid_we, ifid_flush, idex_we, idex_kill, busy;
`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt [3];
  logic [31:0] flush_cnt [3];
`endif

  always #5 clk = ~clk;

  id_hazard_ctrl #(.LU_STALL_CYCLES(1), .FLUSH_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .idex_MemRead(idex_MemRead), .idex_DestReg(idex_DestReg),
    .exmem_MemRead(exmem_MemRead), .exmem_DestReg(exmem_DestReg),
    .branch_taken(branch_taken), .dmem_wait(dmem_wait),
    .pc_we(pc_we[0]), .ifid_we(ifid_we[0]), .ifid_flush(ifid_flush[0]),
    .idex_we(idex_we[0]), .idex_kill(idex_kill[0]), .busy(busy[0])
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
`endif
  );

  id_hazard_ctrl #(.LU_STALL_CYCLES(2), .FLUSH_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .idex_MemRead(idex_MemRead), .idex_DestReg(idex_DestReg),
    .exmem_MemRead(exmem_MemRead), .exmem_DestReg(exmem_DestReg),
    .branch_taken(branch_taken), .dmem_wait(dmem_wait),
    .pc_we(pc_we[1]), .ifid_we(ifid_we[1]), .ifid_flush(ifid_flush[1]),
    .idex_we(idex_we[1]), .idex_kill(idex_kill[1]), .busy(busy[1])
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
`endif
  );

  id_hazard_ctrl #(.LU_STALL_CYCLES(1), .FLUSH_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .idex_MemRead(idex_MemRead), .idex_DestReg(idex_DestReg),
    .exmem_MemRead(exmem_MemRead), .exmem_DestReg(exmem_DestReg),
    .branch_taken(branch_taken), .dmem_wait(dmem_wait),
    .pc_we(pc_we[2]), .ifid_we(ifid_we[2]), .ifid_flush(ifid_flush[2]),
    .idex_we(idex_we[2]), .idex_kill(idex_kill[2]), .busy(busy[2])
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt[2]), .flush_cnt(flush_cnt[2])
`endif
  );

  // Output word: {pc_we, ifid_we, ifid_flush, idex_we, idex_kill, busy}
  localparam logic [5:0] P_RST   = 6'b111110;
  localparam logic [5:0] P_RUN   = 6'b110100;
  localparam logic [5:0] P_FLUSH = 6'b111110;
  localparam logic [5:0] P_STALL = 6'b000110;
  localparam logic [5:0] P_FRZ   = 6'b000000;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic       urs;
    logic [4:0] rt;
    logic       urt;
    logic       exr;
    logic [4:0] exd;
    logic       mmr;
    logic [4:0] mmd;
    logic       br;
    logic       dw;
    logic [5:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: extra flush / stall cycles still owed, per configuration.
  int lu_cfg [3] = '{1, 2, 1};
  int fl_cfg [3] = '{1, 2, 3};
  int fl_left [3] = '{0, 0, 0};
  int st_left [3] = '{0, 0, 0};
  int m_stall [3] = '{0, 0, 0};
  int m_flush [3] = '{0, 0, 0};

  function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic urs,
                              input logic [4:0] rt, input logic urt, input logic exr,
                              input logic [4:0] exd, input logic mmr, input logic [4:0] mmd,
                              input logic br, input logic dw, input logic [5:0] exp);
    vec_t v;
    v.rst = r; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
    v.exr = exr; v.exd = exd; v.mmr = mmr; v.mmd = mmd;
    v.br = br; v.dw = dw; v.exp = exp;
    return v;
  endfunction

  function automatic logic [5:0] dout(input int k);
    return {pc_we[k], ifid_we[k], ifid_flush[k], idex_we[k], idex_kill[k], busy[k]};
  endfunction

  function automatic bit hits(input logic rd, input logic [4:0] d);
    return rd && (d != 0) && ((id_uses_rs && id_rs == d) || (id_uses_rt && id_rt == d));
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d cycle %0d: got %0h want %0h", name, k, cyc, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; id_rs = v.rs; id_uses_rs = v.urs; id_rt = v.rt; id_uses_rt = v.urt;
    idex_MemRead = v.exr; idex_DestReg = v.exd;
    exmem_MemRead = v.mmr; exmem_DestReg = v.mmd;
    branch_taken = v.br; dmem_wait = v.dw;
  endtask

  // Compare all DUTs against the model for the current cycle, then advance it.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic [5:0] e;
      bit hex, lu, bsy;
      hex = hits(idex_MemRead, idex_DestReg);
      lu  = hex || (lu_cfg[k] == 2 && hits(exmem_MemRead, exmem_DestReg));
      bsy = (fl_left[k] > 0) || (st_left[k] > 0);
`ifdef HAZ_STATS_EN
      chk("stall_cnt", k, stall_cnt[k], 32'(m_stall[k]));
      chk("flush_cnt", k, flush_cnt[k], 32'(m_flush[k]));
`endif
      if (rst) begin
        e = P_RST; fl_left[k] = 0; st_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end else if (dmem_wait) begin
        e = P_FRZ | 6'(bsy);
      end else if (branch_taken) begin
        e = P_FLUSH | 6'(bsy); fl_left[k] = fl_cfg[k] - 1; st_left[k] = 0; m_flush[k]++;
      end else if (fl_left[k] > 0) begin
        e = P_FLUSH | 6'(bsy); fl_left[k]--; m_flush[k]++;
      end else if (st_left[k] > 0) begin
        e = P_STALL | 6'(bsy); st_left[k]--; m_stall[k]++;
      end else if (lu) begin
        e = P_STALL | 6'(bsy); m_stall[k]++;
        if (hex && lu_cfg[k] == 2) st_left[k] = 1;
      end else begin
        e = P_RUN | 6'(bsy);
      end
      chk("outputs", k, 32'(dout(k)), 32'(e));
    end
  endtask

  task automatic run_cycle(input vec_t v);
    drive(v);
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  vec_t tbl [25];
  vec_t rv;

  initial begin
    // Directed sequence; exp is the cfg1 (LU=2, FLUSH=2) response.
    tbl[0]  = mk(1, 0,0, 0,0, 0,0, 0,0, 0,0, P_RST);
    tbl[1]  = mk(1, 0,0, 0,0, 0,0, 0,0, 0,0, P_RST);
    tbl[2]  = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_RUN);
    tbl[3]  = mk(0, 5,1, 0,0, 1,5, 0,0, 0,0, P_STALL);
    tbl[4]  = mk(0, 5,1, 0,0, 1,5, 0,0, 0,0, P_STALL | 6'd1);
    tbl[5]  = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_RUN);
    tbl[6]  = mk(0, 0,1, 0,0, 1,0, 0,0, 0,0, P_RUN);
    tbl[7]  = mk(0, 0,0, 7,1, 0,0, 1,7, 0,0, P_STALL);
    tbl[8]  = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_RUN);
    tbl[9]  = mk(0, 5,1, 0,0, 1,5, 0,0, 1,0, P_FLUSH);
    tbl[10] = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_FLUSH | 6'd1);
    tbl[11] = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_RUN);
    tbl[12] = mk(0, 5,1, 0,0, 1,5, 0,0, 0,0, P_STALL);
    tbl[13] = mk(0, 0,0, 0,0, 0,0, 0,0, 1,0, P_FLUSH | 6'd1);
    tbl[14] = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_FLUSH | 6'd1);
    tbl[15] = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_RUN);
    tbl[16] = mk(0, 0,0, 0,0, 0,0, 0,0, 1,0, P_FLUSH);
    tbl[17] = mk(0, 0,0, 0,0, 0,0, 0,0, 0,1, P_FRZ | 6'd1);
    tbl[18] = mk(0, 0,0, 0,0, 0,0, 0,0, 1,1, P_FRZ | 6'd1);
    tbl[19] = mk(0, 0,0, 0,0, 0,0, 0,0, 0,1, P_FRZ | 6'd1);
    tbl[20] = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_FLUSH | 6'd1);
    tbl[21] = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_RUN);
    tbl[22] = mk(0, 0,0, 9,1, 1,9, 0,0, 0,0, P_STALL);
    tbl[23] = mk(1, 0,0, 0,0, 0,0, 0,0, 0,0, P_RST);
    tbl[24] = mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_RUN);

    drive(tbl[0]);
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk("table", 1, 32'(dout(1)), 32'(tbl[i].exp));
      model_step();
      @(posedge clk);
      #1;
      cyc++;
    end

`ifdef HAZ_STATS_EN
    // Two load-use hazards and one branch on cfg0 (single-cycle flush).
    run_cycle(mk(1, 0,0, 0,0, 0,0, 0,0, 0,0, P_RST));
    run_cycle(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_RUN));
    run_cycle(mk(0, 3,1, 0,0, 1,3, 0,0, 0,0, P_STALL));
    run_cycle(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_RUN));
    run_cycle(mk(0, 0,0, 4,1, 1,4, 0,0, 0,0, P_STALL));
    run_cycle(mk(0, 0,0, 0,0, 0,0, 0,0, 0,1, P_FRZ));
    run_cycle(mk(0, 0,0, 0,0, 0,0, 0,0, 1,0, P_FLUSH));
    run_cycle(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, P_RUN));
    @(negedge clk);
    chk("stats_stall", 0, stall_cnt[0], 32'd2);
    chk("stats_flush", 0, flush_cnt[0], 32'd1);
    run_cycle(mk(1, 0,0, 0,0, 0,0, 0,0, 0,0, P_RST));
    @(negedge clk);
    chk("stats_stall_rst", 0, stall_cnt[0], 32'd0);
    chk("stats_flush_rst", 0, flush_cnt[0], 32'd0);
    @(posedge clk);
    #1;
`endif

    // Random phase: small register numbers so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      rv.rst = ($urandom_range(0, 59) == 0);
      rv.rs  = 5'($urandom_range(0, 3));
      rv.rt  = 5'($urandom_range(0, 3));
      rv.urs = 1'($urandom_range(0, 1));
      rv.urt = 1'($urandom_range(0, 1));
      rv.exr = ($urandom_range(0, 2) != 0);
      rv.exd = 5'($urandom_range(0, 3));
      rv.mmr = 1'($urandom_range(0, 1));
      rv.mmd = 5'($urandom_range(0, 3));
      rv.br  = ($urandom_range(0, 6) == 0);
      rv.dw  = ($urandom_range(0, 7) == 0);
      rv.exp = '0;
      run_cycle(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
